// File: rtl/axi_rom_rd_slave_pkg.sv
// Shared constants, state encodings and burst address helpers for the AXI ROM read slave.
package axi_rom_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic ok;
    ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return ok;
  endfunction

  // Word address of the beat following addr; WRAP with an illegal length holds the address.
  function automatic logic [29:0] next_word_addr(input logic [29:0] addr,
                                                 input logic [1:0]  burst,
                                                 input logic [7:0]  len);
    logic [29:0] mask;
    logic [29:0] inc;
    logic [29:0] nxt;
    mask = {22'd0, len};
    inc  = addr + 30'd1;
    nxt  = addr;
    case (burst)
      BURST_INCR: nxt = inc;
      BURST_WRAP: if (wrap_len_ok(len)) nxt = (addr & ~mask) | (inc & mask);
      default:    nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_rom_mem.sv
// Synchronous-read word array, zero-initialised; read port updates only when enabled.
module axi_rom_mem #(
  parameter int    MEM_WORDS  = 4096,
  parameter int    MEM_ADDR_W = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  re,
  input  logic [MEM_ADDR_W-1:0] addr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [MEM_WORDS];

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
  end

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // the consumer masks rdata until a valid OKAY beat has been loaded.
  // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_rom_rd_slave.sv
// AXI4 read responder over a ROM image; write bursts are drained and answered with SLVERR.
module axi_rom_rd_slave
  import axi_rom_rd_slave_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter int          MEM_ADDR_W = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o
);

  localparam int TAG_W = 30 - MEM_ADDR_W;
  localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[31:MEM_ADDR_W+2];

  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;
  logic        rdy_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic [29:0] addr_q;
  logic [7:0]  left_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic        data_ok_q;
  logic [3:0]  awid_q;

  logic        ar_hs;
  logic        issue;
  logic [29:0] beat_addr;
  logic [1:0]  beat_burst;
  logic [7:0]  beat_len;
  logic        beat_last;
  logic        beat_bad;
  logic        beat_in_range;
  logic [1:0]  beat_resp;
  logic [31:0] mem_rdata;

  assign ar_hs = axi_arvalid_i && axi_arready_o;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    rd_state_d    = rd_state_q;
    axi_arready_o = 1'b0;
    issue         = 1'b0;
    beat_addr     = addr_q;
    beat_burst    = burst_q;
    beat_len      = len_q;
    beat_last     = (left_q == 8'd1);
    case (rd_state_q)
      RD_IDLE: begin
        axi_arready_o = rdy_q;
        beat_addr     = axi_araddr_i[31:2];
        beat_burst    = axi_arburst_i;
        beat_len      = axi_arlen_i;
        beat_last     = (axi_arlen_i == 8'd0);
        if (axi_arvalid_i && rdy_q) begin
          issue      = 1'b1;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        // A new beat is fetched only when the output register is empty or draining.
        issue = (left_q != 8'd0) && (!rvalid_q || axi_rready_i);
        if (rvalid_q && axi_rready_i && rlast_q) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign beat_bad = (beat_burst == 2'd3) ||
                    ((beat_burst == BURST_WRAP) && !wrap_len_ok(beat_len));
  // BASE_ADDR is aligned to the memory size, so range reduces to a tag compare.
  assign beat_in_range = (beat_addr[29:MEM_ADDR_W] == BASE_TAG);
  assign beat_resp = beat_bad       ? RESP_SLVERR :
                     beat_in_range  ? RESP_OKAY   : RESP_DECERR;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_state_q <= RD_IDLE;
      rdy_q      <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      burst_q    <= BURST_INCR;
      addr_q     <= '0;
      left_q     <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      data_ok_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rdy_q      <= 1'b1;
      if (ar_hs) begin
        id_q    <= axi_arid_i;
        len_q   <= axi_arlen_i;
        burst_q <= axi_arburst_i;
      end
      if (issue) begin
        addr_q    <= next_word_addr(beat_addr, beat_burst, beat_len);
        left_q    <= (rd_state_q == RD_IDLE) ? axi_arlen_i : left_q - 8'd1;
        rvalid_q  <= 1'b1;
        rresp_q   <= beat_resp;
        rlast_q   <= beat_last;
        data_ok_q <= (beat_resp == RESP_OKAY);
      end else if (axi_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  axi_rom_mem #(
    .MEM_WORDS (MEM_WORDS),
    .MEM_ADDR_W(MEM_ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk_i(clk_i),
    .re   (issue),
    .addr (beat_addr[MEM_ADDR_W-1:0]),
    .rdata(mem_rdata)
  );

  assign axi_rvalid_o = rvalid_q;
  assign axi_rdata_o  = data_ok_q ? mem_rdata : 32'd0;
  assign axi_rresp_o  = rresp_q;
  assign axi_rlast_o  = rlast_q;
  assign axi_rid_o    = id_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_state_q <= WR_IDLE;
      awid_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      if (axi_awvalid_i && axi_awready_o) awid_q <= axi_awid_i;
    end
  end

  always_comb begin
    wr_state_d    = wr_state_q;
    axi_awready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_bresp_o   = RESP_OKAY;
    case (wr_state_q)
      WR_IDLE: begin
        axi_awready_o = rdy_q;
        if (axi_awvalid_i && rdy_q) wr_state_d = WR_DATA;
      end
      WR_DATA: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i && axi_wlast_i) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        axi_bvalid_o = 1'b1;
        axi_bresp_o  = RESP_SLVERR;
        if (axi_bready_i) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign axi_bid_o = awid_q;

  // Write payload and byte-lane bits of the read address carry no meaning for a ROM.
  logic unused_inputs;
  assign unused_inputs = ^{axi_araddr_i[1:0], axi_awaddr_i, axi_awlen_i, axi_awburst_i,
                           axi_wdata_i, axi_wstrb_i};

endmodule

// File: tb/tb_axi_rom_rd_slave.sv
// Directed bench for axi_rom_rd_slave: a scoreboard of expected R beats drained by a monitor.
module tb_axi_rom_rd_slave;

  localparam int MEM_WORDS = 4096;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        axi_arvalid_i, axi_arready_o;
  logic [31:0] axi_araddr_i;
  logic [3:0]  axi_arid_i;
  logic [7:0]  axi_arlen_i;
  logic [1:0]  axi_arburst_i;
  logic        axi_rvalid_o, axi_rready_i;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic [3:0]  axi_rid_o;
  logic        axi_rlast_o;
  logic        axi_awvalid_i, axi_awready_o;
  logic [31:0] axi_awaddr_i;
  logic [3:0]  axi_awid_i;
  logic [7:0]  axi_awlen_i;
  logic [1:0]  axi_awburst_i;
  logic        axi_wvalid_i, axi_wready_o;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wstrb_i;
  logic        axi_wlast_i;
  logic        axi_bvalid_o, axi_bready_i;
  logic [1:0]  axi_bresp_o;
  logic [3:0]  axi_bid_o;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ar_cyc = 0;
  int    hs_count = 0;
  int    first_hs_cyc = 0;
  int    last_hs_cyc = 0;
  beat_t sb[$];
  beat_t mon_e;
  bit    rr_pat [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_resp;
  logic        prev_last;

  axi_rom_rd_slave #(
    .MEM_WORDS (MEM_WORDS),
    .MEM_ADDR_W(12),
    .BASE_ADDR (32'h0000_0000),
    .INIT_FILE ("")
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
    .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats of one burst, derived from the protocol rules and memory word k = k.
  task automatic push_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
    logic [29:0] w;
    logic [29:0] m;
    logic        bad;
    beat_t       b;
    w   = addr[31:2];
    m   = {22'd0, len};
    bad = (burst == 2'd3) ||
          (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      if (bad) begin
        b.resp = 2'd2; b.data = 32'd0;
      end else if (w >= 30'(MEM_WORDS)) begin
        b.resp = 2'd3; b.data = 32'd0;
      end else begin
        b.resp = 2'd0; b.data = {2'b00, w};
      end
      sb.push_back(b);
      if (burst == 2'd1) w = w + 30'd1;
      else if (burst == 2'd2) w = (w & ~m) | ((w + 30'd1) & m);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the AR handshake.
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    int n;
    push_burst(addr, len, burst, id);
    axi_arvalid_i = 1'b1;
    axi_araddr_i  = addr;
    axi_arlen_i   = len;
    axi_arburst_i = burst;
    axi_arid_i    = id;
    n = 0;
    while (!axi_arready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("ar_handshake", 32'(axi_arready_o), 32'd1);
    ar_cyc = cyc;
    @(negedge clk_i);
    axi_arvalid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      axi_rready_i = rr_pat[k % 4];
      k++;
      @(negedge clk_i);
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    axi_rready_i = 1'b1;
  endtask

  // R-channel monitor: pops the scoreboard on each handshake and watches stalls.
  always @(negedge clk_i) begin
    #1;
    if (rst_i && prev_stall) begin
      check("stall_rvalid", 32'(axi_rvalid_o), 32'd1);
      check("stall_rdata", axi_rdata_o, prev_data);
      check("stall_rresp", 32'(axi_rresp_o), 32'(prev_resp));
      check("stall_rlast", 32'(axi_rlast_o), 32'(prev_last));
    end
    if (rst_i && axi_rvalid_o && axi_rready_i) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL r_unexpected_beat: observed data %h with nothing expected", axi_rdata_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rdata", axi_rdata_o, mon_e.data);
        check("rresp", 32'(axi_rresp_o), 32'(mon_e.resp));
        check("rlast", 32'(axi_rlast_o), 32'(mon_e.last));
        check("rid", 32'(axi_rid_o), 32'(mon_e.id));
      end
      if (hs_count == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_count++;
    end
    prev_stall = rst_i && axi_rvalid_o && !axi_rready_i;
    prev_data  = axi_rdata_o;
    prev_resp  = axi_rresp_o;
    prev_last  = axi_rlast_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    axi_arvalid_i = 1'b0; axi_araddr_i = '0; axi_arid_i = '0; axi_arlen_i = '0; axi_arburst_i = '0;
    axi_rready_i = 1'b1;
    axi_awvalid_i = 1'b0; axi_awaddr_i = '0; axi_awid_i = '0; axi_awlen_i = '0; axi_awburst_i = '0;
    axi_wvalid_i = 1'b0; axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0;
    axi_bready_i = 1'b0;
    #1;
    for (int k = 0; k < MEM_WORDS; k++) dut.u_mem.mem[k] = 32'(k);

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_arready", 32'(axi_arready_o), 32'd0);
    check("rst_rvalid", 32'(axi_rvalid_o), 32'd0);
    check("rst_rlast", 32'(axi_rlast_o), 32'd0);
    check("rst_rdata", axi_rdata_o, 32'd0);
    check("rst_rresp", 32'(axi_rresp_o), 32'd0);
    check("rst_rid", 32'(axi_rid_o), 32'd0);
    check("rst_awready", 32'(axi_awready_o), 32'd0);
    check("rst_wready", 32'(axi_wready_o), 32'd0);
    check("rst_bvalid", 32'(axi_bvalid_o), 32'd0);
    check("rst_bresp", 32'(axi_bresp_o), 32'd0);
    check("rst_bid", 32'(axi_bid_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_arready", 32'(axi_arready_o), 32'd1);
    check("post_rst_awready", 32'(axi_awready_o), 32'd1);

    // INCR len=7 at 0x20 with rready high: timing of first/last beat and arready return
    hs_count = 0;
    send_ar(32'h20, 8'd7, 2'd1, 4'd8);
    drain(100);
    check("incr_beats", 32'(hs_count), 32'd8);
    check("incr_first_cyc", 32'(first_hs_cyc - ar_cyc), 32'd1);
    check("incr_last_cyc", 32'(last_hs_cyc - ar_cyc), 32'd8);
    check("incr_arready_cyc", 32'(cyc - ar_cyc), 32'd9);
    check("incr_arready", 32'(axi_arready_o), 32'd1);

    // Same burst with rready pattern 1,0,0,1
    rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs_count = 0;
    send_ar(32'h20, 8'd7, 2'd1, 4'd8);
    drain(100);
    check("stall_beats", 32'(hs_count), 32'd8);
    rr_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

    // WRAP, FIXED, len=0, illegal WRAP length, reserved burst type, top-of-memory crossing
    send_ar(32'h38, 8'd3, 2'd2, 4'd1);
    drain(50);
    send_ar(32'h10, 8'd2, 2'd0, 4'd2);
    drain(50);
    hs_count = 0;
    send_ar(32'h44, 8'd0, 2'd1, 4'd3);
    drain(50);
    check("len0_beats", 32'(hs_count), 32'd1);
    send_ar(32'h80, 8'd2, 2'd2, 4'd4);
    drain(50);
    send_ar(32'h80, 8'd1, 2'd3, 4'd6);
    drain(50);
    send_ar(32'h3FF8, 8'd3, 2'd1, 4'd7);
    drain(50);

    // Write burst with a concurrent read of the same region
    axi_awvalid_i = 1'b1; axi_awid_i = 4'd5; axi_awlen_i = 8'd3;
    axi_awaddr_i = 32'h40; axi_awburst_i = 2'd1;
    check("aw_ready", 32'(axi_awready_o), 32'd1);
    @(negedge clk_i);
    axi_awvalid_i = 1'b0;
    check("w_ready_after_aw", 32'(axi_wready_o), 32'd1);
    send_ar(32'h40, 8'd3, 2'd1, 4'd9);
    for (int b = 0; b < 4; b++) begin
      axi_wvalid_i = 1'b1;
      axi_wdata_i  = 32'hDEAD_0000 | 32'(b);
      axi_wstrb_i  = 4'hF;
      axi_wlast_i  = (b == 3);
      check("w_ready_beat", 32'(axi_wready_o), 32'd1);
      @(negedge clk_i);
    end
    axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
    check("b_valid", 32'(axi_bvalid_o), 32'd1);
    check("b_resp", 32'(axi_bresp_o), 32'd2);
    check("b_id", 32'(axi_bid_o), 32'd5);
    check("w_ready_done", 32'(axi_wready_o), 32'd0);
    @(negedge clk_i);
    check("b_valid_hold", 32'(axi_bvalid_o), 32'd1);
    axi_bready_i = 1'b1;
    @(negedge clk_i);
    axi_bready_i = 1'b0;
    check("b_valid_clear", 32'(axi_bvalid_o), 32'd0);
    check("aw_ready_again", 32'(axi_awready_o), 32'd1);
    drain(50);
    send_ar(32'h40, 8'd3, 2'd1, 4'd10);
    drain(50);

    // Reset asserted while the third beat of an 8-beat burst is presented
    hs_count = 0;
    send_ar(32'h100, 8'd7, 2'd1, 4'd11);
    for (int n = 0; n < 20 && hs_count < 2; n++) @(negedge clk_i);
    check("midrst_beats_before", 32'(hs_count), 32'd2);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_rvalid", 32'(axi_rvalid_o), 32'd0);
    check("midrst_arready", 32'(axi_arready_o), 32'd0);
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    check("midrst_arready_after", 32'(axi_arready_o), 32'd1);
    check("midrst_rvalid_after", 32'(axi_rvalid_o), 32'd0);
    hs_count = 0;
    send_ar(32'h100, 8'd7, 2'd1, 4'd12);
    drain(100);
    check("midrst_fresh_beats", 32'(hs_count), 32'd8);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
